// File: rtl/async_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count, threshold flags
// and one-cycle overflow/underflow error pulses.
module async_fifo #(
  parameter int unsigned DATA_WIDTH          = 8,
  parameter int unsigned FIFO_DEPTH          = 16,
  parameter int unsigned PTR_WIDTH           = 5,
  parameter int unsigned ALMOST_FULL_THRESH  = 14,
  parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic [PTR_WIDTH-1:0]  count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned AddrWidth = $clog2(FIFO_DEPTH);
  localparam logic [PTR_WIDTH-1:0] AfThresh = PTR_WIDTH'(ALMOST_FULL_THRESH);
  localparam logic [PTR_WIDTH-1:0] AeThresh = PTR_WIDTH'(ALMOST_EMPTY_THRESH);
  localparam logic [PTR_WIDTH-1:0] PtrOne   = PTR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, underflow_q;
  logic                  do_write, do_read;
  logic [AddrWidth-1:0]  wr_addr, rd_addr;

  assign wr_addr = wr_ptr_q[AddrWidth-1:0];
  assign rd_addr = rd_ptr_q[AddrWidth-1:0];

  // Status is derived purely from the registered pointers; the MSB is the wrap bit.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_WIDTH-1] != rd_ptr_q[PTR_WIDTH-1]) && (wr_addr == rd_addr);
  assign count = wr_ptr_q - rd_ptr_q;

  assign almost_full  = (count >= AfThresh);
  assign almost_empty = (count <= AeThresh);
  assign data_out     = empty ? '0 : mem[rd_addr];
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign do_write = wr_en && !full;
  assign do_read  = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_write) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_read)  rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_addr] <= data_in;
  end

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo: reset, fill/drain, underflow,
// wrap-around ordering, simultaneous access and threshold flags.
module tb_async_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] data_in;
  logic       full;
  logic       rd_en;
  logic [7:0] data_out;
  logic       empty;
  logic [4:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int tests_run;
  int tests_failed;

  async_fifo #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(16),
    .PTR_WIDTH(5),
    .ALMOST_FULL_THRESH(14),
    .ALMOST_EMPTY_THRESH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .data_in(data_in),
    .full(full),
    .rd_en(rd_en),
    .data_out(data_out),
    .empty(empty),
    .count(count),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and return on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;
    #3;
    tests_run++;
    if ({empty, full, count, almost_empty, almost_full, data_out, overflow, underflow} !==
        {1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_init: e=%b f=%b cnt=%0d ae=%b af=%b dout=%h ov=%b un=%b req e=1 f=0 cnt=0 ae=1 af=0 dout=00 ov=0 un=0",
               empty, full, count, almost_empty, almost_full, data_out, overflow, underflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      data_in = 8'hC0 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    tests_run++;
    if ({count, data_out} !== {5'd3, 8'hC0}) begin
      tests_failed++;
      $display("FAIL reset_prefill: cnt=%0d dout=%h req cnt=3 dout=c0", count, data_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({empty, full, count, data_out} !== {1'b1, 1'b0, 5'd0, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset_async: e=%b f=%b cnt=%0d dout=%h req e=1 f=0 cnt=0 dout=00",
               empty, full, count, data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      data_in = 8'(i);
      step();
      tests_run++;
      if ({count, full, almost_full} !== {5'(i + 1), (i == 15), (i + 1 >= 14)}) begin
        tests_failed++;
        $display("FAIL fill_%0d: cnt=%0d f=%b af=%b req cnt=%0d f=%b af=%b",
                 i, count, full, almost_full, i + 1, (i == 15), (i + 1 >= 14));
      end
    end
    data_in = 8'hAA;
    step();
    wr_en = 1'b0;
    tests_run++;
    if ({overflow, count, full} !== {1'b1, 5'd16, 1'b1}) begin
      tests_failed++;
      $display("FAIL overflow_pulse: ov=%b cnt=%0d f=%b req ov=1 cnt=16 f=1", overflow, count, full);
    end
    step();
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_clear: ov=%b req 0", overflow);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tests_run++;
      if (data_out !== 8'(i)) begin
        tests_failed++;
        $display("FAIL drain_%0d: dout=%h req %h", i, data_out, 8'(i));
      end
      step();
    end
    rd_en = 1'b0;
    tests_run++;
    if ({empty, count, data_out, underflow} !== {1'b1, 5'd0, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL drain_end: e=%b cnt=%0d dout=%h un=%b req e=1 cnt=0 dout=00 un=0",
               empty, count, data_out, underflow);
    end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    tests_run++;
    if ({underflow, empty, count, data_out} !== {1'b1, 1'b1, 5'd0, 8'h00}) begin
      tests_failed++;
      $display("FAIL underflow_pulse: un=%b e=%b cnt=%0d dout=%h req un=1 e=1 cnt=0 dout=00",
               underflow, empty, count, data_out);
    end
    step();
    tests_run++;
    if ({underflow, empty} !== {1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL underflow_clear: un=%b e=%b req un=0 e=1", underflow, empty);
    end
    // A read pointer that moved on the ignored pop would surface here.
    wr_en   = 1'b1;
    data_in = 8'h77;
    step();
    wr_en = 1'b0;
    tests_run++;
    if ({count, data_out} !== {5'd1, 8'h77}) begin
      tests_failed++;
      $display("FAIL underflow_ptr: cnt=%0d dout=%h req cnt=1 dout=77", count, data_out);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_wrap();
    int wr_n = 0;
    int rd_n = 0;
    int gap  = 0;
    int cyc  = 0;
    while (rd_n < 50 && cyc < 3000) begin
      wr_en = 1'b0;
      rd_en = 1'b0;
      if (wr_n < 50 && gap == 0 && !full) begin
        wr_en   = 1'b1;
        data_in = 8'(wr_n);
      end
      if (!empty && ($urandom_range(1, 0) == 1)) begin
        rd_en = 1'b1;
        tests_run++;
        if (data_out !== 8'(rd_n)) begin
          tests_failed++;
          $display("FAIL wrap_pop_%0d: dout=%h req %h", rd_n, data_out, 8'(rd_n));
        end
      end
      step();
      if (wr_en) begin
        wr_n++;
        gap = $urandom_range(2, 0);
      end else if (gap > 0) begin
        gap--;
      end
      if (rd_en) rd_n++;
      cyc++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    tests_run++;
    if ({rd_n, empty} !== {32'd50, 1'b1}) begin
      tests_failed++;
      $display("FAIL wrap_done: popped=%0d e=%b req popped=50 e=1", rd_n, empty);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      data_in = 8'h10 + 8'(i);
      step();
    end
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 8'hEE;
    tests_run++;
    if ({full, data_out} !== {1'b1, 8'h10}) begin
      tests_failed++;
      $display("FAIL sim_full_pre: f=%b dout=%h req f=1 dout=10", full, data_out);
    end
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    tests_run++;
    if ({count, overflow, full, data_out} !== {5'd15, 1'b1, 1'b0, 8'h11}) begin
      tests_failed++;
      $display("FAIL sim_full: cnt=%0d ov=%b f=%b dout=%h req cnt=15 ov=1 f=0 dout=11",
               count, overflow, full, data_out);
    end
    for (int i = 1; i < 16; i++) begin
      rd_en = 1'b1;
      tests_run++;
      if (data_out !== 8'h10 + 8'(i)) begin
        tests_failed++;
        $display("FAIL sim_drain_%0d: dout=%h req %h", i, data_out, 8'h10 + 8'(i));
      end
      step();
    end
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    data_in = 8'h5A;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    tests_run++;
    if ({count, underflow, data_out} !== {5'd1, 1'b1, 8'h5A}) begin
      tests_failed++;
      $display("FAIL sim_empty: cnt=%0d un=%b dout=%h req cnt=1 un=1 dout=5a",
               count, underflow, data_out);
    end
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 8'h33;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    tests_run++;
    if ({count, data_out, overflow, underflow} !== {5'd1, 8'h33, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL sim_mid: cnt=%0d dout=%h ov=%b un=%b req cnt=1 dout=33 ov=0 un=0",
               count, data_out, overflow, underflow);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_thresholds();
    int n = 0;
    for (int i = 0; i < 33; i++) begin
      tests_run++;
      if ({count, almost_empty, almost_full, empty, full} !==
          {5'(n), (n <= 2), (n >= 14), (n == 0), (n == 16)}) begin
        tests_failed++;
        $display("FAIL thresh_step%0d: cnt=%0d ae=%b af=%b e=%b f=%b req cnt=%0d ae=%b af=%b e=%b f=%b",
                 i, count, almost_empty, almost_full, empty, full,
                 n, (n <= 2), (n >= 14), (n == 0), (n == 16));
      end
      if (i < 16) begin
        wr_en   = 1'b1;
        data_in = 8'hF0 ^ 8'(i);
        step();
        wr_en = 1'b0;
        n++;
      end else if (i < 32) begin
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        n--;
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_wrap();
    test_simultaneous();
    test_thresholds();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- Single-clock, first-word-fall-through (FWFT) FIFO buffer between a producer and a consumer that share one clock.
- Default storage: 16 x 8-bit.
- Provides full/empty, occupancy count, almost-full/almost-empty thresholds and per-cycle overflow/underflow error pulses.
- Used as a rate-decoupling buffer in datapaths where the producer and consumer issue bursty, independent requests.

Parameters:
- DATA_WIDTH, 8: width of data_in/data_out.
- FIFO_DEPTH, 16: number of entries; must be a power of two, >= 2.
- PTR_WIDTH, 5: pointer width = log2(FIFO_DEPTH)+1; the MSB is the wrap bit.
- ALMOST_FULL_THRESH, 14: almost_full asserts when count >= this value.
- ALMOST_EMPTY_THRESH, 2: almost_empty asserts when count <= this value.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request; data_in is captured on the rising edge when wr_en=1 and full=0.
- data_in  input  DATA_WIDTH  write data.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- rd_en  input  1  read/pop request; pops on the rising edge when rd_en=1 and empty=0.
- data_out  output  DATA_WIDTH  head-of-FIFO data (FWFT).
- empty  output  1  FIFO holds 0 entries.
- count  output  PTR_WIDTH  current occupancy, 0..FIFO_DEPTH.
- almost_full  output  1  count >= ALMOST_FULL_THRESH.
- almost_empty  output  1  count <= ALMOST_EMPTY_THRESH.
- overflow  output  1  one-cycle pulse: a write was attempted while full.
- underflow  output  1  one-cycle pulse: a read was attempted while empty.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (async assert, release on any edge): wr_ptr=0, rd_ptr=0, overflow=0, underflow=0. Resulting outputs: empty=1, full=0, count=0, almost_empty=1, almost_full=0, data_out=0. Memory contents are not reset.
- Reset mid-operation discards all stored data immediately.
- Pointers: PTR_WIDTH bits; address = low log2(FIFO_DEPTH) bits; the MSB toggles on each wrap.
- Write: when wr_en && !full, mem[wr_ptr addr] <= data_in and wr_ptr increments by 1 (mod 2^PTR_WIDTH).
- Read: when rd_en && !empty, rd_ptr increments by 1.
- empty = (wr_ptr == rd_ptr). Combinational from registered pointers.
- full = (MSBs differ && lower bits equal). Combinational from registered pointers.
- count = wr_ptr - rd_ptr, modulo 2^PTR_WIDTH.
- FWFT output:
  - data_out = mem[rd_ptr addr] combinationally while !empty, and is 0 while empty.
  - The first written word appears on data_out in the cycle after its write edge.
  - After a pop edge, data_out shows the next entry (or 0 if the FIFO became empty).
  - The value consumed by a pop is the value on data_out immediately before that edge.
- Write while full: ignored; memory and pointers unchanged; overflow=1 for the next cycle.
- Read while empty: ignored; underflow=1 for the next cycle.
- Simultaneous wr_en and rd_en, neither blocked: both occur; count unchanged.
- Simultaneous, full: read occurs, write ignored (overflow pulses); afterwards count = FIFO_DEPTH-1.
- Simultaneous, empty: write occurs, read ignored (underflow pulses); afterwards count = 1.
- No same-cycle bypass: a word written on an edge cannot be popped on that same edge.
- Data order is strictly preserved across pointer wrap-around; no data loss or duplication at any depth.

Test Plan:
- Reset: assert rst_n=0 mid-simulation with entries stored -> empty=1, full=0, count=0, data_out=0 immediately (asynchronously), before any clk edge.
- Fill/drain: write 0x00..0x0F with no reads -> full=1 after the 16th write edge, almost_full=1 from count 14. A 17th write (0xAA) -> overflow pulse, count stays 16. Then read 16 times -> data 0x00..0x0F in order, empty=1 after the last pop.
- Underflow: rd_en=1 on an empty FIFO -> underflow pulses for one cycle, rd_ptr unchanged, data_out=0.
- Wrap-around: 50 writes of an incrementing pattern (0x00..0x31) with random 0-2 cycle gaps, interleaved with random reads gated on !empty -> every popped value equals the running read count, zero mismatches.
- Simultaneous: at count=16 assert wr_en and rd_en together -> head popped, write dropped, count=15. At count=0 assert both -> count=1, data_out = written value next cycle.
- Thresholds: step count 0->16->0 -> almost_empty=1 for count<=2, almost_full=1 for count>=14, count output matches at every step.
